// File: rtl/sort_controller.sv
`default_nettype none
// ============================================================================
//  Module   : sort_controller
//  Brief    : Loads a batch of DEPTH unsigned words, bubble-sorts them in
//             place one compare/swap per cycle with early exit on a clean
//             pass, then streams them out in ascending order.
//  Revision : 1.0 - initial release
// ============================================================================
module sort_controller #(
    parameter int NUM_BITS = 4,
    parameter int DEPTH    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [NUM_BITS-1:0] in_data,
    output logic                in_ready,
    output logic                out_valid,
    output logic [NUM_BITS-1:0] out_data,
    input  logic                out_ready,
    output logic                busy
);

    // Pointer width covers indices 0..DEPTH-1 (DEPTH is 2..16).
    localparam int                 C_PTR_W    = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [C_PTR_W-1:0] C_PTR_ZERO = '0;
    localparam logic [C_PTR_W-1:0] C_PTR_ONE  = C_PTR_W'(1);
    localparam logic [C_PTR_W-1:0] C_LAST_PTR = C_PTR_W'(DEPTH - 1);
    localparam logic [C_PTR_W-1:0] C_LAST_IDX = C_PTR_W'(DEPTH - 2);

    // State encoding.
    localparam logic [1:0] C_ST_LOAD  = 2'd0;
    localparam logic [1:0] C_ST_SORT  = 2'd1;
    localparam logic [1:0] C_ST_DRAIN = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;

    logic [NUM_BITS-1:0] r_mem [DEPTH];
    logic [C_PTR_W-1:0]  r_wr_ptr;
    logic [C_PTR_W-1:0]  r_idx;
    logic [C_PTR_W-1:0]  r_rd_ptr;
    logic                r_swap;

    logic [C_PTR_W-1:0]  w_idx_nxt;
    logic                w_gt;
    logic                w_load_we;
    logic                w_sort_en;
    logic                w_drain_pop;

    // Neighbour under comparison this cycle; strict greater-than keeps equal
    // words in their original order.
    assign w_idx_nxt = r_idx + C_PTR_ONE;
    assign w_gt      = r_mem[r_idx] > r_mem[w_idx_nxt];

    // Sorted word is only presented while draining; zero otherwise so no
    // partial or stale batch data is visible.
    assign out_data  = (r_state == C_ST_DRAIN) ? r_mem[r_rd_ptr] : '0;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= C_ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_load_we   = 1'b0;
        w_sort_en   = 1'b0;
        w_drain_pop = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            C_ST_LOAD: begin
                in_ready  = 1'b1;
                w_load_we = in_valid;
                if (in_valid && (r_wr_ptr == C_LAST_PTR)) begin
                    w_state_nxt = C_ST_SORT;
                end
            end
            C_ST_SORT: begin
                busy      = 1'b1;
                w_sort_en = 1'b1;
                // A pass with no swap, counting this cycle's compare, means
                // the array is ordered.
                if ((r_idx == C_LAST_IDX) && !(r_swap || w_gt)) begin
                    w_state_nxt = C_ST_DRAIN;
                end
            end
            C_ST_DRAIN: begin
                out_valid   = 1'b1;
                w_drain_pop = out_ready;
                if (out_ready && (r_rd_ptr == C_LAST_PTR)) begin
                    w_state_nxt = C_ST_LOAD;
                end
            end
            default: begin
                w_state_nxt = C_ST_LOAD;
            end
        endcase
    end

    // Storage array and pointers: load writes, in-place compare/swap, drain reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= C_PTR_ZERO;
            r_idx    <= C_PTR_ZERO;
            r_rd_ptr <= C_PTR_ZERO;
            r_swap   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_load_we) begin
                r_mem[r_wr_ptr] <= in_data;
                r_wr_ptr        <= (r_wr_ptr == C_LAST_PTR) ? C_PTR_ZERO
                                                            : r_wr_ptr + C_PTR_ONE;
            end

            if (w_sort_en) begin
                if (w_gt) begin
                    r_mem[r_idx]     <= r_mem[w_idx_nxt];
                    r_mem[w_idx_nxt] <= r_mem[r_idx];
                end
                if (r_idx == C_LAST_IDX) begin
                    // End of pass: restart the scan with a fresh swap flag.
                    r_idx  <= C_PTR_ZERO;
                    r_swap <= 1'b0;
                end else begin
                    r_idx  <= w_idx_nxt;
                    r_swap <= r_swap | w_gt;
                end
            end

            if (w_drain_pop) begin
                r_rd_ptr <= (r_rd_ptr == C_LAST_PTR) ? C_PTR_ZERO
                                                     : r_rd_ptr + C_PTR_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sort_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sort_controller
//  Brief    : Self-checking bench for sort_controller; expected order and
//             sort duration come from a rank/displacement model of the batch.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sort_controller;

    localparam int NB    = 4;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [NB-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [NB-1:0] out_data;
    logic          out_ready;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [NB-1:0] batch_words [DEPTH];
    logic [NB-1:0] exp_words   [DEPTH];

    sort_controller #(
        .NUM_BITS (NB),
        .DEPTH    (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bubble sort needs one swapping pass per step of the largest leftward
    // displacement, then one clean pass.
    function automatic int model_busy();
        int worst;
        int c;
        worst = 0;
        for (int i = 0; i < DEPTH; i++) begin
            c = 0;
            for (int j = 0; j < i; j++) begin
                if (batch_words[j] > batch_words[i]) c++;
            end
            if (c > worst) worst = c;
        end
        return (worst + 1) * (DEPTH - 1);
    endfunction

    // Stable ascending order by rank: smaller words first, ties by position.
    task automatic model_sort();
        int rank;
        for (int i = 0; i < DEPTH; i++) begin
            rank = 0;
            for (int j = 0; j < DEPTH; j++) begin
                if (batch_words[j] < batch_words[i]) rank++;
                else if ((batch_words[j] == batch_words[i]) && (j < i)) rank++;
            end
            exp_words[rank] = batch_words[i];
        end
    endtask

    // Load batch_words, time the sort, drain and check the stream.
    task automatic run_batch(input string tag, input bit toggle, input int stall,
                             input bit rand_stall);
        int busy_cnt;
        int exp_busy;
        int guard;
        int k;
        int stall_left;
        model_sort();
        exp_busy = model_busy();

        for (int i = 0; i < DEPTH; i++) begin
            if (toggle && (i > 0)) begin
                in_valid = 1'b0;
                in_data  = NB'($urandom);
                step();
            end
            in_valid = 1'b1;
            in_data  = batch_words[i];
            n_tests++;
            if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL %s load_ready word%0d: in_ready=%b busy=%b out_valid=%b required 1,0,0",
                         tag, i, in_ready, busy, out_valid);
            end
            step();
        end

        busy_cnt = 0;
        guard    = 0;
        while (busy === 1'b1 && guard < 200) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = NB'($urandom);
            n_tests++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL %s sort_flags: in_ready=%b out_valid=%b required 0,0",
                         tag, in_ready, out_valid);
            end
            busy_cnt++;
            guard++;
            step();
        end
        n_tests++;
        if (busy_cnt != exp_busy) begin
            n_fail++;
            $display("FAIL %s busy_cycles: got %0d required %0d", tag, busy_cnt, exp_busy);
        end

        k          = 0;
        guard      = 0;
        stall_left = stall;
        while (k < DEPTH && guard < 200) begin
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = rand_stall ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            in_valid = 1'($urandom_range(0, 1));
            in_data  = NB'($urandom);
            n_tests++;
            if (out_valid !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 ||
                out_data !== exp_words[k]) begin
                n_fail++;
                $display("FAIL %s drain word%0d: out_valid=%b busy=%b in_ready=%b out_data=%0d required 1,0,0,%0d",
                         tag, k, out_valid, busy, in_ready, out_data, exp_words[k]);
            end
            if (out_ready) k++;
            guard++;
            step();
        end
        n_tests++;
        if (k != DEPTH) begin
            n_fail++;
            $display("FAIL %s drain_timeout: drained %0d required %0d", tag, k, DEPTH);
        end

        out_ready = 1'b0;
        in_valid  = 1'b0;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0) begin
            n_fail++;
            $display("FAIL %s return_load: in_ready=%b out_valid=%b busy=%b out_data=%0d required 1,0,0,0",
                     tag, in_ready, out_valid, busy, out_data);
        end
    endtask

    task automatic set_batch(input int a, input int b, input int c, input int d);
        batch_words[0] = NB'(a);
        batch_words[1] = NB'(b);
        batch_words[2] = NB'(c);
        batch_words[3] = NB'(d);
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 4'd9;
        out_ready = 1'b0;
        step();
        step();
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset in_ready: got %b required 1", in_ready);
        end
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset out_valid: got %b required 0", out_valid);
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset busy: got %b required 0", busy);
        end
        n_tests++;
        if (out_data !== '0) begin
            n_fail++;
            $display("FAIL reset out_data: got %0d required 0", out_data);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_reverse();
        set_batch(15, 10, 5, 0);
        run_batch("reverse", 1'b0, 0, 1'b0);
    endtask

    task automatic test_sorted();
        set_batch(1, 2, 3, 4);
        run_batch("sorted", 1'b0, 0, 1'b0);
    endtask

    task automatic test_equal();
        set_batch(7, 7, 7, 7);
        run_batch("equal", 1'b0, 0, 1'b0);
    endtask

    task automatic test_stall_toggle();
        set_batch(9, 0, 9, 0);
        run_batch("stall_toggle", 1'b1, 3, 1'b0);
    endtask

    task automatic test_mid_sort_reset();
        set_batch(15, 10, 5, 0);
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1;
            in_data  = batch_words[i];
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        step();
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset in_sort: busy=%b required 1", busy);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_tests++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_data !== '0) begin
            n_fail++;
            $display("FAIL mid_reset after: in_ready=%b busy=%b out_valid=%b out_data=%0d required 1,0,0,0",
                     in_ready, busy, out_valid, out_data);
        end
        set_batch(3, 1, 2, 0);
        run_batch("mid_reset_new", 1'b0, 0, 1'b0);
    endtask

    task automatic test_pairs();
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                set_batch(a, b, 15, 0);
                run_batch("pairs", 1'b0, 0, 1'b0);
            end
        end
    endtask

    task automatic test_back_to_back_random();
        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < DEPTH; i++) begin
                batch_words[i] = (n % 2 == 0) ? NB'($urandom_range(0, 15))
                                              : NB'($urandom_range(0, 3));
            end
            run_batch("random", 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'b1);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #1;
        test_reset();
        test_reverse();
        test_sorted();
        test_equal();
        test_stall_toggle();
        test_mid_sort_reset();
        test_pairs();
        test_back_to_back_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
